multicycle_control_unit: RTL and testbench

Multi-cycle successor to the single-cycle opcode decoder: a Moore/Mealy FSM that sequences each instruction through fetch, decode, execute, memory and write-back, and drives the datapath control strobes for each phase. Opcode width is parametrised, memory accesses use a ready handshake, and ALUOp is widened to 2 bits. It sits between the instruction register and the datapath/memory interface of the CPU.

---
 rtl/cu_pkg.sv | 71 +++++++
 rtl/cu_perf_counter.sv | 29 ++
 rtl/multicycle_control_unit.sv | 129 ++++++++++++
 tb/tb_multicycle_control_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types for the multi-cycle control unit: FSM states, opcode classes,
// ALUOp encodings and the datapath strobe bundle with its per-state decode.
package cu_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
  } state_e;

  typedef enum logic [1:0] {
    CLS_R      = 2'd0,
    CLS_LOAD   = 2'd1,
    CLS_STORE  = 2'd2,
    CLS_BRANCH = 2'd3
  } op_class_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       ior_d;
    logic       busy;
  } strobes_t;

  localparam strobes_t STROBES_DEFAULT = '0;

  // Moore strobes for a given state and latched opcode class.
  function automatic strobes_t strobe_decode(state_e st, op_class_e cls);
    strobes_t s;
    s = STROBES_DEFAULT;
    unique case (st)
      S_FETCH: s.mem_read = 1'b1;
      S_EXEC: begin
        unique case (cls)
          CLS_R:      s.alu_op = ALUOP_FUNCT;
          CLS_BRANCH: begin
            s.alu_op = ALUOP_SUB;
            s.branch = 1'b1;
          end
          default: begin
            s.alu_src = 1'b1;
            s.alu_op  = ALUOP_ADD;
          end
        endcase
      end
      S_MEM: begin
        s.ior_d     = 1'b1;
        s.alu_src   = 1'b1;
        s.mem_read  = (cls == CLS_LOAD);
        s.mem_write = (cls == CLS_STORE);
      end
      S_WB: begin
        s.reg_write  = 1'b1;
        s.reg_dst    = (cls == CLS_R);
        s.mem_to_reg = (cls == CLS_LOAD);
      end
      default: ;
    endcase
    s.busy = (st != S_IDLE);
    return s;
  endfunction

endpackage

// File: rtl/cu_perf_counter.sv
// Event counter for the control-unit performance monitors; SATURATE selects
// saturating (stick at all-ones) or wrapping behaviour.
module cu_perf_counter #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !(SATURATE && (&count_q))) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory
// ready handshake. Optional performance counters under CU_PERF_COUNT_EN.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int OP_WIDTH  = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                input_Reset_n,
  input  logic [OP_WIDTH-1:0] input_Operator,
  input  logic                input_MemReady,
  output logic                output_RegDst,
  output logic                output_RegWrite,
  output logic                output_ALUSrc,
  output logic                output_Branch,
  output logic                output_MemRead,
  output logic                output_MemWrite,
  output logic                output_MemtoReg,
  output logic [1:0]          output_ALUOp,
  output logic                output_IorD,
  output logic                output_IRWrite,
  output logic                output_PCWrite,
  output logic                output_Illegal,
  output logic                output_Busy
`ifdef CU_PERF_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] output_InstrCount,
  output logic [CNT_WIDTH-1:0] output_StallCount
`endif
);

  if (OP_WIDTH < 2) begin : g_bad_op_width
    $error("OP_WIDTH must be at least 2");
  end

  state_e    state_q, state_d;
  op_class_e class_q, class_d;
  strobes_t  strobes_q, strobes_d;

  // The IR is only loaded at the end of FETCH, so legality is judged on the
  // live opcode while in DECODE; everything afterwards uses the latched class.
  logic      op_legal;
  op_class_e op_class;
  assign op_legal = ((input_Operator >> 2) == '0);
  assign op_class = op_class_e'(input_Operator[1:0]);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    class_d = class_q;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (input_MemReady) state_d = S_DECODE;
      S_DECODE: begin
        class_d = op_class;
        state_d = op_legal ? S_EXEC : S_FETCH;
      end
      S_EXEC: begin
        unique case (class_q)
          CLS_R:      state_d = S_WB;
          CLS_BRANCH: state_d = S_FETCH;
          default:    state_d = S_MEM;
        endcase
      end
      S_MEM: if (input_MemReady) state_d = (class_q == CLS_LOAD) ? S_WB : S_FETCH;
      S_WB:    state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
    // Registering the decode of the next state keeps strobes glitch-free yet
    // aligned with the state they belong to.
    strobes_d = strobe_decode(state_d, class_d);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge input_Reset_n) begin
    if (!input_Reset_n) begin
      state_q   <= S_IDLE;
      class_q   <= CLS_R;
      strobes_q <= STROBES_DEFAULT;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      strobes_q <= strobes_d;
    end
  end

  assign output_RegDst   = strobes_q.reg_dst;
  assign output_RegWrite = strobes_q.reg_write;
  assign output_ALUSrc   = strobes_q.alu_src;
  assign output_Branch   = strobes_q.branch;
  assign output_MemRead  = strobes_q.mem_read;
  assign output_MemWrite = strobes_q.mem_write;
  assign output_MemtoReg = strobes_q.mem_to_reg;
  assign output_ALUOp    = strobes_q.alu_op;
  assign output_IorD     = strobes_q.ior_d;
  assign output_Busy     = strobes_q.busy;

  assign output_IRWrite = (state_q == S_FETCH) && input_MemReady;
  assign output_PCWrite = (state_q == S_FETCH) && input_MemReady;
  assign output_Illegal = (state_q == S_DECODE) && !op_legal;

`ifdef CU_PERF_COUNT_EN
  logic instr_inc, stall_inc;
  assign instr_inc = (state_q == S_DECODE) && op_legal;
  assign stall_inc = ((state_q == S_FETCH) || (state_q == S_MEM)) && !input_MemReady;

  cu_perf_counter #(.WIDTH(CNT_WIDTH), .SATURATE(1'b0)) u_instr_count (
    .clk   (clk),
    .rst_n (input_Reset_n),
    .inc   (instr_inc),
    .count (output_InstrCount)
  );

  cu_perf_counter #(.WIDTH(CNT_WIDTH), .SATURATE(1'b1)) u_stall_count (
    .clk   (clk),
    .rst_n (input_Reset_n),
    .inc   (stall_inc),
    .count (output_StallCount)
  );
`else
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("CNT_WIDTH must be at least 1");
  end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: expected per-cycle strobes are
// queued per instruction and compared as the DUT steps through its states.
module tb_multicycle_control_unit;

  localparam int OP_W  = 3;
  localparam int CNT_W = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [OP_W-1:0] op;
  logic            mem_ready;
  logic            reg_dst, reg_write, alu_src, branch, mem_read, mem_write, mem_to_reg;
  logic [1:0]      alu_op;
  logic            ior_d, ir_write, pc_write, illegal, busy;
`ifdef CU_PERF_COUNT_EN
  logic [CNT_W-1:0] instr_count, stall_count;
`endif

  multicycle_control_unit #(.OP_WIDTH(OP_W), .CNT_WIDTH(CNT_W)) dut (
    .clk             (clk),
    .input_Reset_n   (rst_n),
    .input_Operator  (op),
    .input_MemReady  (mem_ready),
    .output_RegDst   (reg_dst),
    .output_RegWrite (reg_write),
    .output_ALUSrc   (alu_src),
    .output_Branch   (branch),
    .output_MemRead  (mem_read),
    .output_MemWrite (mem_write),
    .output_MemtoReg (mem_to_reg),
    .output_ALUOp    (alu_op),
    .output_IorD     (ior_d),
    .output_IRWrite  (ir_write),
    .output_PCWrite  (pc_write),
    .output_Illegal  (illegal),
    .output_Busy     (busy)
`ifdef CU_PERF_COUNT_EN
    ,
    .output_InstrCount (instr_count),
    .output_StallCount (stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Observation vector bit map (MSB..LSB): RegDst RegWrite ALUSrc Branch
  // MemRead MemWrite MemtoReg ALUOp[1:0] IorD IRWrite PCWrite Illegal Busy
  localparam logic [13:0] B_REGDST = 14'h2000, B_REGWR  = 14'h1000;
  localparam logic [13:0] B_ALUSRC = 14'h0800, B_BRANCH = 14'h0400;
  localparam logic [13:0] B_MEMRD  = 14'h0200, B_MEMWR  = 14'h0100;
  localparam logic [13:0] B_M2R    = 14'h0080, B_FUNCT  = 14'h0040;
  localparam logic [13:0] B_SUB    = 14'h0020, B_IORD   = 14'h0010;
  localparam logic [13:0] B_IRWR   = 14'h0008, B_PCWR   = 14'h0004;
  localparam logic [13:0] B_ILL    = 14'h0002, B_BUSY   = 14'h0001;

  typedef struct {
    logic [13:0] outs;
    logic        ready;
    logic [2:0]  op;
    string       tag;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] instr_exp;
  logic [3:0] stall_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [13:0] observe();
    return {reg_dst, reg_write, alu_src, branch, mem_read, mem_write, mem_to_reg,
            alu_op, ior_d, ir_write, pc_write, illegal, busy};
  endfunction

  function automatic logic [2:0] junk_op();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic logic junk_ready();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [13:0] outs, input logic ready, input logic [2:0] o,
                      input string tag);
    exp_t e;
    e.outs = outs; e.ready = ready; e.op = o; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic stall_tick();
    if (stall_exp != 4'hF) stall_exp = stall_exp + 4'd1;
  endtask

  // Reference sequence of one instruction, with fw FETCH and mw MEM wait cycles.
  task automatic push_instr(input logic [2:0] o, input int fw, input int mw);
    string nm;
    nm = $sformatf("op%0d", o);
    for (int i = 0; i < fw; i++) begin
      push(B_BUSY | B_MEMRD, 1'b0, junk_op(), {nm, ".fetch_wait"});
      stall_tick();
    end
    push(B_BUSY | B_MEMRD | B_IRWR | B_PCWR, 1'b1, junk_op(), {nm, ".fetch"});
    if (o >= 3'd4) begin
      push(B_BUSY | B_ILL, junk_ready(), o, {nm, ".decode_illegal"});
      return;
    end
    push(B_BUSY, junk_ready(), o, {nm, ".decode"});
    instr_exp = instr_exp + 4'd1;
    case (o)
      3'd0: begin
        push(B_BUSY | B_FUNCT, junk_ready(), junk_op(), {nm, ".exec"});
        push(B_BUSY | B_REGWR | B_REGDST, junk_ready(), junk_op(), {nm, ".wb"});
      end
      3'd1, 3'd2: begin
        logic [13:0] m;
        m = B_BUSY | B_IORD | B_ALUSRC | ((o == 3'd1) ? B_MEMRD : B_MEMWR);
        push(B_BUSY | B_ALUSRC, junk_ready(), junk_op(), {nm, ".exec"});
        for (int i = 0; i < mw; i++) begin
          push(m, 1'b0, junk_op(), {nm, ".mem_wait"});
          stall_tick();
        end
        push(m, 1'b1, junk_op(), {nm, ".mem"});
        if (o == 3'd1) push(B_BUSY | B_REGWR | B_M2R, junk_ready(), junk_op(), {nm, ".wb"});
      end
      default: push(B_BUSY | B_SUB | B_BRANCH, junk_ready(), junk_op(), {nm, ".exec"});
    endcase
  endtask

  // One scoreboard entry per clock: drive on the falling edge, sample 1 later.
  task automatic run_entries(input int n);
    exp_t e;
    for (int i = 0; i < n && sb_q.size() > 0; i++) begin
      e = sb_q.pop_front();
      @(negedge clk);
      mem_ready = e.ready;
      op        = e.op;
      #1;
      check(e.tag, 32'(observe()), 32'(e.outs));
    end
  endtask

  task automatic run_all();
    run_entries(sb_q.size());
`ifdef CU_PERF_COUNT_EN
    check("instr_count", 32'(instr_count), 32'(instr_exp));
    check("stall_count", 32'(stall_count), 32'(stall_exp));
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    op        = '0;
    instr_exp = '0;
    stall_exp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_idle", 32'(observe()), 32'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    op        = '0;
    instr_exp = '0;
    stall_exp = '0;

    do_reset();

    push_instr(3'd0, 0, 0);   // R-type, no waits
    run_all();
    push_instr(3'd1, 0, 3);   // load, 3 MEM waits
    run_all();
    push_instr(3'd2, 1, 0);   // store then branch back-to-back
    push_instr(3'd3, 0, 0);
    run_all();
    push_instr(3'd5, 0, 0);   // illegal opcodes
    push_instr(3'd7, 2, 0);
    push_instr(3'd0, 0, 0);
    run_all();

    // Asynchronous reset in the middle of a load's MEM wait.
    push_instr(3'd1, 0, 5);
    run_entries(5);
    check("pre_rst_memread", 32'(mem_read), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", 32'(observe()), 32'h0);
`ifdef CU_PERF_COUNT_EN
    check("rst_async_instr", 32'(instr_count), 32'h0);
    check("rst_async_stall", 32'(stall_count), 32'h0);
`endif
    sb_q.delete();
    do_reset();
    push_instr(3'd0, 0, 0);
    run_all();

    // Counter boundaries: 17 instructions wrap a 4-bit count, 20 stalls saturate.
    do_reset();
    push_instr(3'd3, 20, 0);
    run_all();
    for (int i = 0; i < 16; i++) begin
      push_instr(3'd3, 0, 0);
      run_entries(sb_q.size());
    end
`ifdef CU_PERF_COUNT_EN
    check("instr_wrap", 32'(instr_count), 32'h1);
    check("stall_saturate", 32'(stall_count), 32'hF);
`endif
    push_instr(3'd0, 0, 0);
    run_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
